// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Machine-mode trap entry/exit sequencer sitting in front of the CSR file.
//   Accepts synchronous exceptions, MRET and the machine timer interrupt while
//   idle, then drives hardware write strobes/data for MEPC, MCAUSE, MTVAL and
//   MSTATUS, stalls the core, and finishes with a one-cycle fetch redirect.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   timeint             timer interrupt level (mtime >= mtimecmp)
//   conflict            CSR block saw a software write collide with ours
//   mstatus_in/mie_in   current MSTATUS / MIE
//   mtvec_in/mepc_in    current MTVEC / MEPC
//   pc                  PC to save into MEPC
//   boundary            instruction boundary (interrupts only taken here)
//   exc_valid/cause/tval synchronous exception request
//   mret, debug         MRET executing, core in debug mode
//   busy                stall request
//   redirect/_pc        one-cycle PC redirect and its target
//   m*_out / m*_write   hardware CSR write data / strobes
module trap_sequencer #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMER_CAUSE = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            timeint,
  input  logic            conflict,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mie_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic [XLEN-1:0] pc,
  input  logic            boundary,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            debug,
  output logic            busy,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mepc_out,
  output logic            mepc_write,
  output logic [XLEN-1:0] mcause_out,
  output logic            mcause_write,
  output logic [XLEN-1:0] mtval_out,
  output logic            mtval_write,
  output logic [XLEN-1:0] mstatus_out,
  output logic            mstatus_write
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAVE   = 3'd1,
    STATUS = 3'd2,
    RET    = 3'd3,
    JUMP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] rpc_q, rpc_d;

  logic            take_exc, take_ret, take_irq;
  logic [XLEN-1:0] base, vec_target, irq_cause;
  logic [XLEN-1:0] mstatus_trap, mstatus_ret;
  logic            unused_mie_bits;

  assign unused_mie_bits = ^{mie_in[XLEN-1:8], mie_in[6:0]};

  assign take_exc = exc_valid && !debug;
  assign take_ret = mret && !debug;
  assign take_irq = boundary && !debug && mstatus_in[3] && mie_in[7] && timeint;

  assign base       = {mtvec_in[XLEN-1:2], 2'b00};
  assign vec_target = base + XLEN'(4 * TIMER_CAUSE);

  always_comb begin
    irq_cause           = '0;
    irq_cause[XLEN-1]   = 1'b1;
    irq_cause[XLEN-2:0] = (XLEN-1)'(TIMER_CAUSE);
  end

  always_comb begin
    mstatus_trap        = mstatus_in;
    mstatus_trap[7]     = mstatus_in[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
    mstatus_ret         = mstatus_in;
    mstatus_ret[3]      = mstatus_in[7];
    mstatus_ret[7]      = 1'b1;
    mstatus_ret[12:11]  = 2'b11;
  end

  always_comb begin
    state_d  = state_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    target_d = target_q;
    rpc_d    = rpc_q;
    case (state_q)
      IDLE: begin
        if (take_exc) begin
          state_d  = SAVE;
          epc_d    = pc;
          cause_d  = XLEN'(exc_cause);
          tval_d   = exc_tval;
          target_d = base;
        end else if (take_ret) begin
          state_d = RET;
        end else if (take_irq) begin
          state_d  = SAVE;
          epc_d    = pc;
          cause_d  = irq_cause;
          tval_d   = '0;
          // Only mode 01 vectors, and only for interrupts; 10/11 act as direct.
          target_d = (mtvec_in[1:0] == 2'b01) ? vec_target : base;
        end
      end
      SAVE: begin
        if (!conflict) state_d = STATUS;
      end
      STATUS: begin
        if (!conflict) begin
          state_d = JUMP;
          rpc_d   = target_q;
        end
      end
      RET: begin
        if (!conflict) begin
          state_d = JUMP;
          rpc_d   = mepc_in;
        end
      end
      JUMP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      target_q <= '0;
      rpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      target_q <= target_d;
      rpc_q    <= rpc_d;
    end
  end

  // Outputs are forced low while rst is asserted, even before the reset edge.
  always_comb begin
    busy          = 1'b0;
    redirect      = 1'b0;
    mepc_out      = '0;
    mepc_write    = 1'b0;
    mcause_out    = '0;
    mcause_write  = 1'b0;
    mtval_out     = '0;
    mtval_write   = 1'b0;
    mstatus_out   = '0;
    mstatus_write = 1'b0;
    if (!rst) begin
      busy = (state_q != IDLE);
      case (state_q)
        SAVE: begin
          mepc_write   = 1'b1;
          mepc_out     = epc_q;
          mcause_write = 1'b1;
          mcause_out   = cause_q;
          mtval_write  = 1'b1;
          mtval_out    = tval_q;
        end
        STATUS: begin
          mstatus_write = 1'b1;
          mstatus_out   = mstatus_trap;
        end
        RET: begin
          mstatus_write = 1'b1;
          mstatus_out   = mstatus_ret;
        end
        JUMP:    redirect = 1'b1;
        default: ;
      endcase
    end
  end

  assign redirect_pc = rpc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;
  localparam int NCYC = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        timeint = 1'b0, conflict = 1'b0, boundary = 1'b0;
  logic        exc_valid = 1'b0, mret = 1'b0, debug = 1'b0;
  logic [4:0]  exc_cause = '0;
  logic [31:0] mstatus_in = '0, mie_in = '0, mtvec_in = '0, mepc_in = '0;
  logic [31:0] pc = '0, exc_tval = '0;
  logic        busy, redirect, mepc_write, mcause_write, mtval_write, mstatus_write;
  logic [31:0] redirect_pc, mepc_out, mcause_out, mtval_out, mstatus_out;

  trap_sequencer #(.XLEN(32), .TIMER_CAUSE(7)) dut (
    .clk(clk), .rst(rst), .timeint(timeint), .conflict(conflict),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .pc(pc), .boundary(boundary), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_tval(exc_tval), .mret(mret), .debug(debug), .busy(busy), .redirect(redirect),
    .redirect_pc(redirect_pc), .mepc_out(mepc_out), .mepc_write(mepc_write),
    .mcause_out(mcause_out), .mcause_write(mcause_write), .mtval_out(mtval_out),
    .mtval_write(mtval_write), .mstatus_out(mstatus_out), .mstatus_write(mstatus_write)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy; logic redir; logic [31:0] rpc;
    logic epc_w; logic [31:0] epc;
    logic cause_w; logic [31:0] cause;
    logic tval_w; logic [31:0] tval;
    logic mst_w; logic [31:0] mst;
  } trace_t;

  trace_t      obs [NCYC];
  trace_t      exp_tr [NCYC];
  logic [31:0] exp_rpc = '0;
  int          total = 0;
  int          bad = 0;

  // Reference model: 0 none, 1 exception, 2 timer interrupt, 3 return
  function automatic int classify();
    if (debug) return 0;
    if (exc_valid) return 1;
    if (mret) return 3;
    if (boundary && mstatus_in[3] && mie_in[7] && timeint) return 2;
    return 0;
  endfunction

  function automatic trace_t blank();
    trace_t t;
    t = '0;
    t.rpc = exp_rpc;
    return t;
  endfunction

  task automatic model_txn(input int kind, input logic [NCYC-1:0] cpat);
    int k = 0;
    logic [31:0] target;
    trace_t t;
    if (kind == 1 || kind == 2) begin
      target = mtvec_in & ~32'h3;
      if (kind == 2 && (mtvec_in % 4) == 1) target = target + 4 * 7;
      do begin
        t = blank(); t.busy = 1;
        t.epc_w = 1; t.epc = pc;
        t.cause_w = 1; t.cause = (kind == 1) ? 32'(exc_cause) : 32'h8000_0000 + 7;
        t.tval_w = 1; t.tval = (kind == 1) ? exc_tval : 32'h0;
        exp_tr[k] = t; k++;
      end while (cpat[k-1] && k < NCYC);
      do begin
        t = blank(); t.busy = 1; t.mst_w = 1;
        t.mst = (mstatus_in & ~32'h1888) | (((mstatus_in >> 3) & 1) << 7) | 32'h1800;
        exp_tr[k] = t; k++;
      end while (cpat[k-1] && k < NCYC);
    end else if (kind == 3) begin
      target = mepc_in;
      do begin
        t = blank(); t.busy = 1; t.mst_w = 1;
        t.mst = (mstatus_in & ~32'h1888) | (((mstatus_in >> 7) & 1) << 3) | 32'h1880;
        exp_tr[k] = t; k++;
      end while (cpat[k-1] && k < NCYC);
    end
    if (kind != 0 && k < NCYC) begin
      exp_rpc = target;
      t = blank(); t.busy = 1; t.redir = 1;
      exp_tr[k] = t; k++;
    end
    while (k < NCYC) begin
      exp_tr[k] = blank(); k++;
    end
  endtask

  // Lets the event be sampled at the next edge, then records NCYC cycles.
  task automatic fire_and_capture(input logic [NCYC-1:0] cpat);
    @(posedge clk);
    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      obs[k] = {busy, redirect, redirect_pc, mepc_write, mepc_out, mcause_write, mcause_out,
                mtval_write, mtval_out, mstatus_write, mstatus_out};
      if (k == 0) begin
        exc_valid = 0; mret = 0; timeint = 0; boundary = 0;
      end
      conflict = cpat[k];
    end
    conflict = 0;
  endtask

  task automatic setup_irq(input logic [31:0] vec);
    mstatus_in = 32'h8; mie_in = 32'h80; timeint = 1; boundary = 1;
    pc = 32'h100; mtvec_in = vec; debug = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, redirect, redirect_pc, mepc_write, mcause_write, mtval_write, mstatus_write} !== '0) begin
      bad++; $display("FAIL reset_hold busy=%b redir=%b rpc=%h strobes=%b%b%b%b expected all 0",
                      busy, redirect, redirect_pc, mepc_write, mcause_write, mtval_write, mstatus_write);
    end
    rst = 0; exp_rpc = '0;
    @(negedge clk);
    total++;
    if ({busy, redirect, redirect_pc, mepc_out, mstatus_out} !== '0) begin
      bad++; $display("FAIL reset_idle busy=%b redir=%b rpc=%h expected 0", busy, redirect, redirect_pc);
    end
  endtask

  task automatic test_timer_irq();
    int nb = 0;
    setup_irq(32'h200);
    model_txn(classify(), '0);
    fire_and_capture('0);
    for (int k = 0; k < NCYC; k++) begin
      total++;
      if (obs[k] !== exp_tr[k]) begin
        bad++; $display("FAIL timer cyc%0d got=%h exp=%h", k, obs[k], exp_tr[k]);
      end
      nb += int'(obs[k].busy);
    end
    total++;
    if (!(obs[0].cause === 32'h8000_0007 && obs[1].mst === 32'h1880 && obs[2].redir === 1'b1 && obs[2].rpc === 32'h200)) begin
      bad++; $display("FAIL timer_values cause=%h mst=%h redir=%b rpc=%h exp 80000007/1880/1/200",
                      obs[0].cause, obs[1].mst, obs[2].redir, obs[2].rpc);
    end
    total++;
    if (nb != 3) begin bad++; $display("FAIL timer_busy got=%0d exp=3", nb); end
  endtask

  task automatic test_exc_priority();
    setup_irq(32'h201);
    pc = 32'h40; exc_valid = 1; exc_cause = 5'd2; exc_tval = 32'hDEAD;
    model_txn(classify(), '0);
    fire_and_capture('0);
    for (int k = 0; k < NCYC; k++) begin
      total++;
      if (obs[k] !== exp_tr[k]) begin
        bad++; $display("FAIL exc_prio cyc%0d got=%h exp=%h", k, obs[k], exp_tr[k]);
      end
    end
    total++;
    if (!(obs[0].cause === 32'h2 && obs[0].tval === 32'hDEAD && obs[2].rpc === 32'h200)) begin
      bad++; $display("FAIL exc_values cause=%h tval=%h rpc=%h exp 2/dead/200", obs[0].cause, obs[0].tval, obs[2].rpc);
    end
  endtask

  task automatic test_vectored();
    setup_irq(32'h301);
    model_txn(classify(), '0);
    fire_and_capture('0);
    for (int k = 0; k < NCYC; k++) begin
      total++;
      if (obs[k] !== exp_tr[k]) begin
        bad++; $display("FAIL vectored cyc%0d got=%h exp=%h", k, obs[k], exp_tr[k]);
      end
    end
    total++;
    if (!(obs[2].redir === 1'b1 && obs[2].rpc === 32'h31C)) begin
      bad++; $display("FAIL vectored_pc got=%h exp=31c", obs[2].rpc);
    end
  endtask

  task automatic test_mret();
    mstatus_in = 32'h80; mepc_in = 32'h104; mret = 1; timeint = 0; debug = 0;
    model_txn(classify(), '0);
    fire_and_capture('0);
    for (int k = 0; k < NCYC; k++) begin
      total++;
      if (obs[k] !== exp_tr[k]) begin
        bad++; $display("FAIL mret cyc%0d got=%h exp=%h", k, obs[k], exp_tr[k]);
      end
    end
    total++;
    if (!(obs[0].mst === 32'h1888 && obs[1].redir === 1'b1 && obs[1].rpc === 32'h104)) begin
      bad++; $display("FAIL mret_values mst=%h redir=%b rpc=%h exp 1888/1/104", obs[0].mst, obs[1].redir, obs[1].rpc);
    end
  endtask

  task automatic test_masking();
    for (int c = 0; c < 4; c++) begin
      int nb = 0;
      setup_irq(32'h200);
      case (c)
        0: mstatus_in = 32'h0;
        1: debug = 1;
        2: boundary = 0;
        default: begin debug = 1; exc_valid = 1; mret = 1; end
      endcase
      model_txn(classify(), '0);
      fire_and_capture('0);
      debug = 0;
      for (int k = 0; k < NCYC; k++) begin
        total++;
        if (obs[k] !== exp_tr[k]) begin
          bad++; $display("FAIL mask%0d cyc%0d got=%h exp=%h", c, k, obs[k], exp_tr[k]);
        end
        nb += int'(obs[k].busy);
      end
      total++;
      if (nb != 0) begin bad++; $display("FAIL mask%0d_busy got=%0d exp=0", c, nb); end
    end
  endtask

  task automatic test_conflict();
    int nsave = 0;
    setup_irq(32'h200);
    model_txn(classify(), 12'b011);
    fire_and_capture(12'b011);
    for (int k = 0; k < NCYC; k++) begin
      total++;
      if (obs[k] !== exp_tr[k]) begin
        bad++; $display("FAIL conflict cyc%0d got=%h exp=%h", k, obs[k], exp_tr[k]);
      end
      nsave += int'(obs[k].epc_w);
    end
    total++;
    if (!(nsave == 3 && obs[4].redir === 1'b1 && obs[3].redir === 1'b0)) begin
      bad++; $display("FAIL conflict_latency saves=%0d redir4=%b exp 3/1", nsave, obs[4].redir);
    end
  endtask

  task automatic test_reset_mid();
    int nr = 0;
    setup_irq(32'h200);
    @(posedge clk);
    @(negedge clk);
    timeint = 0; boundary = 0;
    @(negedge clk);
    rst = 1;
    #1;
    total++;
    if ({busy, mstatus_write} !== 2'b00) begin
      bad++; $display("FAIL reset_in_status busy=%b mstatus_write=%b exp 0/0", busy, mstatus_write);
    end
    @(negedge clk);
    rst = 0; exp_rpc = '0;
    total++;
    if ({busy, redirect, redirect_pc, mepc_write, mcause_write, mtval_write, mstatus_write} !== '0) begin
      bad++; $display("FAIL reset_mid_idle busy=%b redir=%b rpc=%h exp 0", busy, redirect, redirect_pc);
    end
    repeat (5) begin
      @(negedge clk);
      nr += int'(redirect) + int'(busy);
    end
    total++;
    if (nr != 0) begin bad++; $display("FAIL reset_mid_after got=%0d busy/redirect cycles exp=0", nr); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      logic [NCYC-1:0] cpat = '0;
      mstatus_in = $urandom; mie_in = $urandom; mtvec_in = $urandom; mepc_in = $urandom;
      pc = $urandom; exc_tval = $urandom; exc_cause = 5'($urandom);
      if ($urandom_range(0, 1) == 1) mstatus_in[3] = 1;
      if ($urandom_range(0, 1) == 1) mie_in[7] = 1;
      if ($urandom_range(0, 2) == 0) mtvec_in[1:0] = 2'b01;
      timeint = ($urandom_range(0, 2) != 0);
      boundary = ($urandom_range(0, 3) != 0);
      exc_valid = ($urandom_range(0, 3) == 0);
      mret = ($urandom_range(0, 3) == 0);
      debug = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < 8; k++) cpat[k] = ($urandom_range(0, 3) == 0);
      model_txn(classify(), cpat);
      fire_and_capture(cpat);
      debug = 0;
      for (int k = 0; k < NCYC; k++) begin
        total++;
        if (obs[k] !== exp_tr[k]) begin
          bad++; $display("FAIL random it%0d cyc%0d got=%h exp=%h", it, k, obs[k], exp_tr[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_timer_irq();
    test_exc_priority();
    test_vectored();
    test_mret();
    test_masking();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
